debounce_pulse_tx: RTL and testbench

Transmit-side counterpart of the input debounce filter: converts single-cycle event requests into clean, glitch-free output pulses whose high and low phases are each held long enough to pass a debounce filter of matching length at the far end. Sits between control logic and an off-chip or cross-board line, for example a handshake line, LED, or relay strobe, whose receiver debounces. Requests arriving while a pulse is in flight are counted and replayed in order, with saturation and overflow flagging.

---
 rtl/debounce_pkg.sv | 14 +
 rtl/debounce_pulse_tx_if.sv | 22 ++
 rtl/hold_timer.sv | 27 ++
 rtl/debounce_pulse_tx.sv | 118 +++++++++++
 tb/tb_debounce_pulse_tx.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared debounce definitions: FSM states and hold constants common to the
// transmit pulse generator and the matching receive filter.
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HIGH      = 2'd1,
      LOW_GUARD = 2'd2
   } state_t;

   localparam int          DEF_CW   = 20;
   localparam int unsigned DEF_HOLD = 32'h0003_0D3F;

endpackage

// File: rtl/debounce_pulse_tx_if.sv
// Request/pulse bundle between control logic (master) and the pulse
// transmitter (slave).
interface debounce_pulse_tx_if #(
   parameter int QW = 4
);
   logic          enable;
   logic          req;
   logic          signal_out;
   logic          busy;
   logic [QW-1:0] pend_cnt;
   logic          overflow;

   modport master (
      output enable, req,
      input  signal_out, busy, pend_cnt, overflow
   );

   modport slave (
      input  enable, req,
      output signal_out, busy, pend_cnt, overflow
   );
endinterface

// File: rtl/hold_timer.sv
// Shared phase-hold counter: counts while enabled, clears synchronously,
// and flags the cycle on which the count equals the terminal value.
module hold_timer
   import debounce_pkg::*;
#(
   parameter int CW = DEF_CW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          en,
   input  logic [CW-1:0] tc_val,
   output logic [CW-1:0] count,
   output logic          tc
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + CW'(1);
      end
   end

   assign tc = en && (count == tc_val);

endmodule

// File: rtl/debounce_pulse_tx.sv
// Turns single-cycle requests into debounce-safe pulses (HIGH_TIME high, at
// least LOW_TIME low); requests during a pulse are counted and replayed.
module debounce_pulse_tx
   import debounce_pkg::*;
#(
   parameter int unsigned HIGH_TIME = DEF_HOLD,
   parameter int unsigned LOW_TIME  = DEF_HOLD,
   parameter int          CW        = DEF_CW,
   parameter int          QW        = 4
) (
   input  logic                clk,
   input  logic                reset,
   debounce_pulse_tx_if.slave  bus
);

   localparam logic [CW-1:0] HIGH_TC  = CW'(HIGH_TIME - 1);
   localparam logic [CW-1:0] LOW_TC   = CW'(LOW_TIME - 1);
   localparam logic [QW-1:0] PEND_MAX = '1;

   state_t        state_q;
   state_t        state_d;
   logic [QW-1:0] pend_q;
   logic          sig_q;
   logic          busy_q;
   logic          ovf_q;

   logic          timer_clr;
   logic          timer_en;
   logic          tc;
   logic [CW-1:0] tc_val;
   logic [CW-1:0] timer_count;

   logic          enq;
   logic          deq;
   logic          drop;

   hold_timer #(.CW(CW)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clr    (timer_clr),
      .en     (timer_en),
      .tc_val (tc_val),
      .count  (timer_count),
      .tc     (tc)
   );

   // Terminal value depends only on the registered state, keeping tc loop-free.
   assign timer_en  = (state_q != IDLE);
   assign tc_val    = (state_q == LOW_GUARD) ? LOW_TC : HIGH_TC;
   assign timer_clr = (state_d != state_q);

   always_comb begin
      state_d = state_q;
      deq     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.enable && (pend_q != '0)) begin
               state_d = HIGH;
               deq     = 1'b1;
            end else if (bus.enable && bus.req) begin
               state_d = HIGH;
            end
         end
         HIGH: begin
            if (tc) begin
               state_d = LOW_GUARD;
            end
         end
         LOW_GUARD: begin
            if (tc) begin
               if (bus.enable && (pend_q != '0)) begin
                  state_d = HIGH;
                  deq     = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A request is queued unless it can start a pulse directly from an empty IDLE.
   assign enq  = bus.req && bus.enable && ((state_q != IDLE) || (pend_q != '0));
   assign drop = enq && (pend_q == PEND_MAX) && !deq;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pend_q  <= '0;
         sig_q   <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sig_q   <= (state_d == HIGH);
         busy_q  <= (state_d != IDLE);
         ovf_q   <= drop;
         case ({enq && !drop, deq})
            2'b10:   pend_q <= pend_q + QW'(1);
            2'b01:   pend_q <= pend_q - QW'(1);
            default: pend_q <= pend_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && (state_q == IDLE)) begin
         assert (timer_count == '0);
      end
   end

   assign bus.signal_out = sig_q;
   assign bus.busy       = busy_q;
   assign bus.pend_cnt   = pend_q;
   assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_debounce_pulse_tx.sv
// Scoreboard bench for debounce_pulse_tx with HIGH_TIME=4, LOW_TIME=3, QW=2.
module tb_debounce_pulse_tx;

   localparam int QW = 2;

   logic clk = 1'b0;
   logic reset;

   debounce_pulse_tx_if #(.QW(QW)) bus ();

   debounce_pulse_tx #(
      .HIGH_TIME (4),
      .LOW_TIME  (3),
      .CW        (20),
      .QW        (QW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int c;
      int len;
   } pulse_t;

   typedef struct {
      int            c;
      logic          sig;
      logic          busy;
      logic [QW-1:0] pend;
      logic          ovf;
   } probe_t;

   pulse_t pulse_q[$];
   int     ovf_q[$];
   probe_t probe_q[$];

   int checks = 0;
   int errors = 0;

   logic   prev_sig = 1'b0;
   int     rise_c   = 0;
   pulse_t pe;
   probe_t pp;
   int     oc;

   // Monitor: compares observed pulses, overflow strobes and probes to the queues.
   always @(negedge clk) begin
      if (bus.signal_out && !prev_sig) rise_c = cyc;
      if (!bus.signal_out && prev_sig) begin
         checks++;
         if (pulse_q.size() == 0) begin
            errors++;
            $display("FAIL pulse_unexpected: start %0d len %0d, no pulse required", rise_c, cyc - rise_c);
         end else begin
            pe = pulse_q.pop_front();
            if (pe.c != rise_c || pe.len != cyc - rise_c) begin
               errors++;
               $display("FAIL pulse: start %0d len %0d, required start %0d len %0d",
                        rise_c, cyc - rise_c, pe.c, pe.len);
            end
         end
      end
      prev_sig = bus.signal_out;

      if (bus.overflow) begin
         checks++;
         if (ovf_q.size() == 0) begin
            errors++;
            $display("FAIL overflow_unexpected: strobe at %0d, none required", cyc);
         end else begin
            oc = ovf_q.pop_front();
            if (oc != cyc) begin
               errors++;
               $display("FAIL overflow: strobe at %0d, required at %0d", cyc, oc);
            end
         end
      end

      while (probe_q.size() > 0 && probe_q[0].c <= cyc) begin
         pp = probe_q.pop_front();
         checks++;
         if (pp.c != cyc || bus.signal_out !== pp.sig || bus.busy !== pp.busy ||
             bus.pend_cnt !== pp.pend || bus.overflow !== pp.ovf) begin
            errors++;
            $display("FAIL probe@%0d (seen %0d): sig %0b busy %0b pend %0d ovf %0b, required %0b %0b %0d %0b",
                     pp.c, cyc, bus.signal_out, bus.busy, bus.pend_cnt, bus.overflow,
                     pp.sig, pp.busy, pp.pend, pp.ovf);
         end
      end
   end

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic req_at(input int c);
      goto(c);
      bus.req = 1'b1;
      goto(c + 1);
      bus.req = 1'b0;
   endtask

   task automatic pr(input int c, input logic s, input logic b, input int p, input logic o);
      probe_t t;
      t.c = c; t.sig = s; t.busy = b; t.pend = QW'(p); t.ovf = o;
      probe_q.push_back(t);
   endtask

   task automatic pl(input int c, input int len);
      pulse_t t;
      t.c = c; t.len = len;
      pulse_q.push_back(t);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      reset      = 1'b1;
      bus.enable = 1'b1;
      bus.req    = 1'b0;
      @(posedge clk); #1;
      pr(3, 0, 0, 0, 0);
      goto(3);
      reset = 1'b0;
      goto(5);

      // Single request
      b = cyc;
      pr(b+10, 0, 0, 0, 0); pr(b+11, 1, 1, 0, 0); pr(b+14, 1, 1, 0, 0);
      pr(b+15, 0, 1, 0, 0); pr(b+17, 0, 1, 0, 0); pr(b+18, 0, 0, 0, 0);
      pl(b+11, 4);
      req_at(b+10);
      goto(b+25);

      // Back-to-back from the queue
      b = cyc;
      pl(b+11, 4); pl(b+18, 4); pl(b+25, 4);
      pr(b+13, 1, 1, 1, 0); pr(b+14, 1, 1, 2, 0); pr(b+17, 0, 1, 2, 0);
      pr(b+18, 1, 1, 1, 0); pr(b+24, 0, 1, 1, 0); pr(b+25, 1, 1, 0, 0);
      req_at(b+10); req_at(b+12); req_at(b+13);
      goto(b+40);

      // Saturation and overflow
      b = cyc;
      pl(b+11, 4); pl(b+18, 4); pl(b+25, 4); pl(b+32, 4);
      ovf_q.push_back(b+15); ovf_q.push_back(b+16);
      pr(b+14, 1, 1, 3, 0); pr(b+15, 0, 1, 3, 1); pr(b+16, 0, 1, 3, 1);
      pr(b+17, 0, 1, 3, 0); pr(b+18, 1, 1, 2, 0); pr(b+25, 1, 1, 1, 0);
      pr(b+32, 1, 1, 0, 0); pr(b+39, 0, 0, 0, 0);
      for (int i = 10; i < 16; i++) req_at(b+i);
      goto(b+45);

      // Enqueue and dequeue on the same cycle at saturation
      b = cyc;
      pl(b+11, 4); pl(b+18, 4); pl(b+25, 4); pl(b+32, 4); pl(b+39, 4);
      pr(b+14, 1, 1, 3, 0); pr(b+17, 0, 1, 3, 0); pr(b+18, 1, 1, 3, 0);
      pr(b+25, 1, 1, 2, 0); pr(b+32, 1, 1, 1, 0); pr(b+39, 1, 1, 0, 0);
      pr(b+46, 0, 0, 0, 0);
      for (int i = 10; i < 14; i++) req_at(b+i);
      req_at(b+17);
      goto(b+52);

      // Request with enable low in IDLE
      b = cyc;
      pr(b+11, 0, 0, 0, 0); pr(b+12, 0, 0, 0, 0);
      goto(b+9);
      bus.enable = 1'b0;
      req_at(b+10);
      goto(b+12);
      bus.enable = 1'b1;
      goto(b+16);

      // Enable dropped mid-pulse, raised later
      b = cyc;
      pl(b+11, 4); pl(b+31, 4);
      pr(b+12, 1, 1, 1, 0); pr(b+18, 0, 0, 1, 0); pr(b+21, 0, 0, 1, 0);
      pr(b+25, 0, 0, 1, 0); pr(b+30, 0, 0, 1, 0); pr(b+31, 1, 1, 0, 0);
      pr(b+38, 0, 0, 0, 0);
      req_at(b+10); req_at(b+11);
      goto(b+12);
      bus.enable = 1'b0;
      req_at(b+20);
      goto(b+30);
      bus.enable = 1'b1;
      goto(b+42);

      // Reset on the second HIGH cycle with two requests pending
      b = cyc;
      pl(b+1, 4); pl(b+11, 2); pl(b+16, 4);
      pr(b+9, 0, 0, 3, 0); pr(b+11, 1, 1, 2, 0); pr(b+12, 1, 1, 2, 0);
      pr(b+13, 0, 0, 0, 0); pr(b+14, 0, 0, 0, 0); pr(b+17, 1, 1, 0, 0);
      pr(b+20, 0, 1, 0, 0); pr(b+23, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) req_at(b+i);
      goto(b+4);
      bus.enable = 1'b0;
      goto(b+10);
      bus.enable = 1'b1;
      goto(b+12);
      reset = 1'b1;
      goto(b+13);
      reset = 1'b0;
      req_at(b+15);
      goto(b+28);

      checks++;
      if (pulse_q.size() != 0 || prev_sig) begin
         errors++;
         $display("FAIL pulses_left: %0d pending, line high %0b, required 0 and 0", pulse_q.size(), prev_sig);
      end
      checks++;
      if (ovf_q.size() != 0) begin
         errors++;
         $display("FAIL overflow_left: %0d strobes not seen, required 0", ovf_q.size());
      end
      checks++;
      if (probe_q.size() != 0) begin
         errors++;
         $display("FAIL probes_left: %0d probes not reached, required 0", probe_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
